ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Round-robin arbiter sharing one port of the 64x16 dual-port block RAM among NUM_REQ requesters.
- Each requester issues single-word read or write commands over a valid/ready handshake.
- The block registers the winning command onto the RAM port and returns read data to the originating requester with a tagged, one-hot response strobe.
- Sits between the RAM's port-A signals (en/we/addr/din/dout) and client engines; port B stays free for another master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 6, RAM address width
DATA_W, 16, RAM data width
RD_LAT, 1, RAM read latency in clocks from sampled command to valid dout (1 for the block RAM)

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_we  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
rsp_valid  out  NUM_REQ  one-hot read-response strobe, one cycle
rsp_rdata  out  DATA_W  read data, valid when any rsp_valid bit set
ram_en  out  1  RAM port enable
ram_we  out  1  RAM port write enable
ram_addr  out  ADDR_W  RAM port address
ram_din  out  DATA_W  RAM port write data
ram_dout  in  DATA_W  RAM port read data

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, tag pipeline cleared, rsp_valid=0. req_ready=0 while rst_n low.
- Arbitration is combinational each cycle. Search req_valid starting at index rr_ptr, ascending with wrap at NUM_REQ. The first set bit wins, and req_ready drives that bit only. req_ready never depends on rsp state; one command is accepted per clock, no bubbles.
- Acceptance: at an edge where req_valid[i] & req_ready[i]:
  - Register ram_en=1, ram_we=req_we[i], ram_addr/ram_din from requester i's slice.
  - rr_ptr <= (i+1) mod NUM_REQ.
- No acceptance: ram_en<=0, ram_we<=0; addr/din hold last value; rr_ptr holds.
- Tag pipeline: depth RD_LAT+1. Entry = {is_read, id}, loaded at acceptance with is_read = ~req_we[i]; shifts every clock.
- Response: rsp_valid[id]=1 for exactly one cycle when the last stage has is_read=1. rsp_rdata = ram_dout passthrough (combinational).
- Latency: read accepted at edge E0 -> rsp_valid high during cycle after edge E(RD_LAT+1). For RD_LAT=1, rsp_valid is high between E2 and E3.
- Writes produce no response; RAM read-before-write data on a write cycle is ignored.
- Back-to-back reads from different requesters give back-to-back responses, in order.
- Requesters must accept rsp_valid unconditionally; there is no response backpressure.
- A requester may drop req_valid before ready without penalty. Command fields are sampled only at the accepting edge.
- Single requester active: granted every cycle (pointer wraps past idle requesters).
- All requesters valid continuously: grants rotate 0,1,2,3,0,... Maximum wait is NUM_REQ-1 cycles.
- Reset mid-operation: in-flight tags are discarded, rsp_valid drops immediately, ram_en=0. Lost reads are not replayed.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'b1111 -> req_ready=0, ram_en=0, rsp_valid=0. After release, first grant goes to requester 0.
- Single read: requester 2 reads addr 6'h05 (preloaded 16'hBEEF), accepted at E0 -> ram_en=1, ram_addr=5 at E1. rsp_valid=4'b0100 with rsp_rdata=16'hBEEF for one cycle after E2.
- Write then read: requester 1 writes 16'h1234 to addr 6'h3F, then reads 6'h3F next cycle -> rsp_valid=4'b0010, rsp_rdata=16'h1234. No response for the write.
- Fairness: all four valid for 8 cycles -> req_ready sequence 0001,0010,0100,1000,0001,0010,0100,1000. Each requester gets exactly 2 grants.
- Skip idle: only requesters 0 and 3 valid, rr_ptr starting at 1 -> grants 3,0,3,0. rsp_valid ids match issue order for reads to distinct addresses.
- Reset mid-flight: two reads accepted, rst_n pulled low one cycle later -> no rsp_valid pulses. After release, the arbiter restarts at requester 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port among NUM_REQ single-word requesters.
// Read data is returned to the issuing requester with a one-hot strobe, in issue order.
module ram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ-1:0]         i_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_wdata,
    output logic [NUM_REQ-1:0]         o_rsp_valid,
    output logic [DATA_W-1:0]          o_rsp_rdata,
    output logic                       o_ram_en,
    output logic                       o_ram_we,
    output logic [ADDR_W-1:0]          o_ram_addr,
    output logic [DATA_W-1:0]          o_ram_din,
    input  logic [DATA_W-1:0]          i_ram_dout
);

    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAGS = RD_LAT + 1;

    logic [IDW-1:0]    r_rr_ptr;
    logic [IDW-1:0]    r_cmd_id;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_tag_rd [TAGS];
    logic [IDW-1:0]    r_tag_id [TAGS];

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_grant_id;
    logic               w_found;

    function automatic logic [IDW-1:0] wrapIdx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDW-1:0];
    endfunction

    // First valid requester at or after the pointer wins; nothing else gets ready.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_req_valid[wrapIdx(r_rr_ptr, k)]) begin
                w_found                     = 1'b1;
                w_grant_id                  = wrapIdx(r_rr_ptr, k);
                w_grant[wrapIdx(r_rr_ptr, k)] = 1'b1;
            end
        end
    end

    assign o_req_ready = rst_n ? w_grant : '0;

    // The registered command (r_ram_en/r_ram_we/r_cmd_id) is the entry point of the tag pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_cmd_id   <= '0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            for (int t = 0; t < TAGS; t++) begin
                r_tag_rd[t] <= 1'b0;
                r_tag_id[t] <= '0;
            end
        end else begin
            r_ram_en <= w_found;
            r_ram_we <= w_found & i_req_we[w_grant_id];
            if (w_found) begin
                r_ram_addr <= i_req_addr[w_grant_id*ADDR_W +: ADDR_W];
                r_ram_din  <= i_req_wdata[w_grant_id*DATA_W +: DATA_W];
                r_cmd_id   <= w_grant_id;
                r_rr_ptr   <= (w_grant_id == IDW'(NUM_REQ-1)) ? '0 : w_grant_id + IDW'(1);
            end
            r_tag_rd[0] <= r_ram_en & ~r_ram_we;
            r_tag_id[0] <= r_cmd_id;
            for (int t = 1; t < TAGS; t++) begin
                r_tag_rd[t] <= r_tag_rd[t-1];
                r_tag_id[t] <= r_tag_id[t-1];
            end
        end
    end

    always_comb begin
        o_rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_tag_rd[TAGS-1] && (r_tag_id[TAGS-1] == IDW'(i))) o_rsp_valid[i] = 1'b1;
        end
    end

    assign o_rsp_rdata = i_ram_dout;
    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_din   = r_ram_din;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a block-RAM model, a command-level
// reference model compared every cycle, and directed literal checks.
module tb_ram_port_arbiter;

    localparam int N   = 4;
    localparam int AW  = 6;
    localparam int DW  = 16;
    localparam int RDL = 1;
    localparam int L   = RDL + 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    reqValid;
    logic [N-1:0]    reqReady;
    logic [N-1:0]    reqWe;
    logic [N*AW-1:0] reqAddr;
    logic [N*DW-1:0] reqWdata;
    logic [N-1:0]    rspValid;
    logic [DW-1:0]   rspRdata;
    logic            ramEn;
    logic            ramWe;
    logic [AW-1:0]   ramAddr;
    logic [DW-1:0]   ramDin;
    logic [DW-1:0]   ramDout;

    int numCompared   = 0;
    int numMismatched = 0;

    ram_port_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_req_valid(reqValid),
        .o_req_ready(reqReady),
        .i_req_we(reqWe),
        .i_req_addr(reqAddr),
        .i_req_wdata(reqWdata),
        .o_rsp_valid(rspValid),
        .o_rsp_rdata(rspRdata),
        .o_ram_en(ramEn),
        .o_ram_we(ramWe),
        .o_ram_addr(ramAddr),
        .o_ram_din(ramDin),
        .i_ram_dout(ramDout)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Power-on RAM contents; address 5 holds the BEEF pattern used by the single-read check.
    function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = {{(DW-AW){1'b0}}, a};
        if (a == 6'h05) return 16'hBEEF;
        return (t * 16'd977) ^ 16'hA500;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] we,
                                 input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        reqValid = v;
        reqWe    = we;
        reqAddr  = a;
        reqWdata = d;
    endtask

    // Block RAM port A: samples the command at a rising edge, read-before-write,
    // and presents read data RDL clocks after that sampling edge.
    bit            memWritten [64];
    logic [DW-1:0] memData    [64];
    bit   [DW-1:0] ramPipe    [RDL+1];

    always @(posedge clk) begin
        if (ramEn) begin
            ramPipe[0] <= memWritten[ramAddr] ? memData[ramAddr] : initWord(ramAddr);
            if (ramWe) begin
                memData[ramAddr]    <= ramDin;
                memWritten[ramAddr] <= 1'b1;
            end
        end else begin
            ramPipe[0] <= '0;
        end
        for (int k = 1; k <= RDL; k++) ramPipe[k] <= ramPipe[k-1];
    end

    assign ramDout = ramPipe[RDL];

    // Reference model: tracks the arbitration pointer, the expected RAM command, a shadow
    // of memory contents in command order, and a timeline of expected responses indexed by
    // "cycles from now". Checks every DUT output mid-cycle, then advances one clock.
    bit            shWritten [64];
    logic [DW-1:0] shData    [64];
    int            modelPtr;
    logic          expEn;
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expDin;
    bit            lineV  [L];
    int            lineId [L];
    logic [DW-1:0] lineD  [L];
    int            mG;
    logic [AW-1:0] mA;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            checkOutput("modelRstReady", reqReady, 0);
            checkOutput("modelRstRamEn", ramEn, 0);
            checkOutput("modelRstRamWe", ramWe, 0);
            checkOutput("modelRstRamAddr", ramAddr, 0);
            checkOutput("modelRstRamDin", ramDin, 0);
            checkOutput("modelRstRsp", rspValid, 0);
            modelPtr = 0;
            expEn    = 1'b0;
            expWe    = 1'b0;
            expAddr  = '0;
            expDin   = '0;
            for (int k = 0; k < L; k++) lineV[k] = 1'b0;
        end else begin
            mG = -1;
            for (int k = 0; k < N; k++)
                if (mG < 0 && reqValid[(modelPtr + k) % N]) mG = (modelPtr + k) % N;
            checkOutput("modelReady", reqReady, (mG >= 0) ? (32'd1 << mG) : 32'd0);
            checkOutput("modelRamEn", ramEn, expEn);
            checkOutput("modelRamWe", ramWe, expWe);
            checkOutput("modelRamAddr", ramAddr, expAddr);
            checkOutput("modelRamDin", ramDin, expDin);
            checkOutput("modelRsp", rspValid, lineV[0] ? (32'd1 << lineId[0]) : 32'd0);
            if (lineV[0]) checkOutput("modelRspData", rspRdata, lineD[0]);

            for (int k = 0; k < L-1; k++) begin
                lineV[k]  = lineV[k+1];
                lineId[k] = lineId[k+1];
                lineD[k]  = lineD[k+1];
            end
            lineV[L-1] = 1'b0;

            if (mG >= 0) begin
                mA       = reqAddr[mG*AW +: AW];
                expEn    = 1'b1;
                expWe    = reqWe[mG];
                expAddr  = mA;
                expDin   = reqWdata[mG*DW +: DW];
                modelPtr = (mG + 1) % N;
                if (reqWe[mG]) begin
                    shData[mA]    = reqWdata[mG*DW +: DW];
                    shWritten[mA] = 1'b1;
                end else begin
                    lineV[L-1]  = 1'b1;
                    lineId[L-1] = mG;
                    lineD[L-1]  = shWritten[mA] ? shData[mA] : initWord(mA);
                end
            end else begin
                expEn = 1'b0;
                expWe = 1'b0;
            end
        end
    end

    // Directed scenarios with hand-computed expectations, then a randomized soak.
    int            grantCount [N];
    logic [N-1:0]  skipSeq    [4];
    logic [AW-1:0] a0;
    logic [AW-1:0] a3;
    logic [N*AW-1:0] rndAddr;
    logic [N*DW-1:0] rndData;
    logic [31:0]     rndWord;

    initial begin
        skipSeq = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) grantCount[i] = 0;
        rst_n = 1'b0;
        applyStimulus(4'b1111, 4'b0000, {6'd3, 6'd2, 6'd1, 6'd0}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady", reqReady, 4'b0000);
        checkOutput("rstRamEn", ramEn, 0);
        checkOutput("rstRsp", rspValid, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] fairness: all requesters valid");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("fairReady", reqReady, 32'd1 << (c % 4));
            for (int i = 0; i < N; i++) grantCount[i] += int'(reqReady[i]);
            @(posedge clk); #1;
        end
        for (int i = 0; i < N; i++) checkOutput("fairCount", grantCount[i], 2);
        applyStimulus('0, '0, '0, '0);
        repeat (4) begin @(posedge clk); #1; end

        $display("[TB] single read from requester 2");
        applyStimulus(4'b0100, 4'b0000, {6'd0, 6'h05, 6'd0, 6'd0}, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("rdReady", reqReady, 4'b0100);
            if (c == 1) begin
                checkOutput("rdRamEn", ramEn, 1);
                checkOutput("rdRamAddr", ramAddr, 6'h05);
            end
            if (c == 3) begin
                checkOutput("rdRsp", rspValid, 4'b0100);
                checkOutput("rdData", rspRdata, 16'hBEEF);
            end
            if (c == 2 || c == 4) checkOutput("rdRspQuiet", rspValid, 4'b0000);
            @(posedge clk); #1;
            if (c == 0) applyStimulus('0, '0, '0, '0);
        end

        $display("[TB] write then read, requester 1");
        applyStimulus(4'b0010, 4'b0010, {6'd0, 6'd0, 6'h3F, 6'd0}, {16'd0, 16'd0, 16'h1234, 16'd0});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("wrRamWe", ramWe, 1);
                checkOutput("wrRamDin", ramDin, 16'h1234);
            end
            if (c == 3 || c == 5) checkOutput("wrNoRsp", rspValid, 4'b0000);
            if (c == 4) begin
                checkOutput("wrRdRsp", rspValid, 4'b0010);
                checkOutput("wrRdData", rspRdata, 16'h1234);
            end
            @(posedge clk); #1;
            if (c == 0) applyStimulus(4'b0010, 4'b0000, {6'd0, 6'd0, 6'h3F, 6'd0}, '0);
            if (c == 1) applyStimulus('0, '0, '0, '0);
        end

        $display("[TB] skip idle requesters");
        applyStimulus(4'b0001, 4'b0001, {6'd0, 6'd0, 6'd0, 6'h30}, {16'd0, 16'd0, 16'd0, 16'h5555});
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                a0 = 6'(16 + c);
                a3 = 6'(32 + c);
                applyStimulus(4'b1001, 4'b0000, {a3, 6'd0, 6'd0, a0}, '0);
            end else begin
                applyStimulus('0, '0, '0, '0);
            end
            @(negedge clk);
            if (c < 4) checkOutput("skipReady", reqReady, skipSeq[c]);
            if (c >= 3 && c < 7) checkOutput("skipRspOrder", rspValid, skipSeq[c-3]);
            @(posedge clk); #1;
        end

        $display("[TB] reset with reads in flight");
        applyStimulus(4'b0110, 4'b0000, {6'd0, 6'h07, 6'h05, 6'd0}, '0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) checkOutput("midRsp", rspValid, 4'b0000);
            if (c == 2) checkOutput("midRamEn", ramEn, 0);
            if (c == 4) checkOutput("restartReady", reqReady, 4'b0001);
            @(posedge clk); #1;
            if (c == 1) begin
                applyStimulus('0, '0, '0, '0);
                rst_n = 1'b0;
            end
            if (c == 3) begin
                rst_n = 1'b1;
                applyStimulus(4'b1111, 4'b0000, {6'd3, 6'd2, 6'd1, 6'd0}, '0);
            end
        end

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                rndWord = $urandom;
                rndAddr[i*AW +: AW] = rndWord[AW-1:0];
                rndData[i*DW +: DW] = rndWord[31:16];
            end
            rndWord = $urandom;
            applyStimulus(rndWord[N-1:0], rndWord[N+3:4], rndAddr, rndData);
            @(posedge clk); #1;
        end
        applyStimulus('0, '0, '0, '0);
        repeat (6) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
